trace_bp_sampler: RTL and testbench

- Trace-debug capture stage between a free-running sample source (no backpressure, may assert valid every cycle) and a downstream FIFO with a ready/valid input.
- Forwards samples unchanged when the FIFO accepts them. Samples that arrive while the output slot is blocked are dropped and counted.
- Reports the number of lost samples in-band with a marker word (MSB = 1) ahead of the next forwarded data.

---
 rtl/trace_bp_sampler_if.sv | 29 ++
 rtl/trace_bp_sampler.sv | 104 ++++++++++
 tb/tb_trace_bp_sampler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/trace_bp_sampler_if.sv
// Bus bundle for trace_bp_sampler: the sample input from a free-running
// trace source and the ready/valid output towards the capture FIFO.
// The slave modport is the sampler's view, the master modport is the
// view of whatever drives samples and consumes FIFO words.
interface trace_bp_sampler_if #(
    parameter int sample_width_p = 4
);
    logic [sample_width_p-1:0] sample_data;
    logic                      sample_valid;
    logic [sample_width_p:0]   fifo_data;
    logic                      fifo_valid;
    logic                      fifo_ready;

    modport slave (
        input  sample_data,
        input  sample_valid,
        output fifo_data,
        output fifo_valid,
        input  fifo_ready
    );

    modport master (
        output sample_data,
        output sample_valid,
        input  fifo_data,
        input  fifo_valid,
        output fifo_ready
    );
endinterface

// File: rtl/trace_bp_sampler.sv
// trace_bp_sampler: trace capture stage between a source that cannot be
// stalled and a ready/valid FIFO. Samples that arrive while the output
// word is blocked are dropped, and the number lost is reported in-band by
// a marker word {1, count} placed where the dropped run would have been.
// Plain data words are {0, sample}.
//
// Build option: define TRACE_BP_MARKER_EN to build the drop counter, the
// one-entry hold register and marker generation. Without it, blocked
// samples are discarded silently and the output MSB is always 0.
module trace_bp_sampler #(
    parameter int sample_width_p  = 4,
    parameter int counter_width_p = 4
) (
    input  logic               clk,
    input  logic               reset_n_i,
    trace_bp_sampler_if.slave  bus
);

    // The drop count must fit inside a marker payload.
    generate
        if (counter_width_p < 1 || counter_width_p > sample_width_p) begin : g_bad_cfg
            $error("trace_bp_sampler: counter_width_p must be in 1..sample_width_p");
        end
    endgenerate

    logic                      fifo_valid_q;
    logic [sample_width_p:0]   fifo_data_q;
    logic                      slot_free;

    // The output word may be replaced when it is empty or leaving this cycle.
    assign slot_free = !fifo_valid_q || bus.fifo_ready;

`ifdef TRACE_BP_MARKER_EN
    logic                       hold_v;
    logic [sample_width_p-1:0]  hold_d;
    logic [counter_width_p-1:0] drop_cnt;
    logic [counter_width_p-1:0] drop_cnt_inc;
    logic [sample_width_p-1:0]  marker_count;

    // Saturating increment: an all-ones count means "at least this many".
    assign drop_cnt_inc = (drop_cnt == {counter_width_p{1'b1}}) ? drop_cnt
                                                                 : drop_cnt + counter_width_p'(1);
    assign marker_count = sample_width_p'(drop_cnt);

    // Output word, hold entry and drop counter, served in order: held
    // sample, then pending marker, then the live sample.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fifo_valid_q <= 1'b0;
            fifo_data_q  <= '0;
            hold_v       <= 1'b0;
            hold_d       <= '0;
            drop_cnt     <= '0;
        end else if (!slot_free) begin
            if (bus.sample_valid) begin
                drop_cnt <= drop_cnt_inc;
            end
        end else if (hold_v) begin
            fifo_valid_q <= 1'b1;
            fifo_data_q  <= {1'b0, hold_d};
            if (bus.sample_valid && drop_cnt == '0) begin
                hold_d <= bus.sample_data;
            end else begin
                hold_v <= 1'b0;
                if (bus.sample_valid) begin
                    drop_cnt <= drop_cnt_inc;
                end
            end
        end else if (drop_cnt != '0) begin
            fifo_valid_q <= 1'b1;
            fifo_data_q  <= {1'b1, marker_count};
            drop_cnt     <= '0;
            hold_v       <= bus.sample_valid;
            if (bus.sample_valid) begin
                hold_d <= bus.sample_data;
            end
        end else if (bus.sample_valid) begin
            fifo_valid_q <= 1'b1;
            fifo_data_q  <= {1'b0, bus.sample_data};
        end else begin
            fifo_valid_q <= 1'b0;
        end
    end
`else
    // Output word only: blocked samples simply vanish.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fifo_valid_q <= 1'b0;
            fifo_data_q  <= '0;
        end else if (slot_free) begin
            if (bus.sample_valid) begin
                fifo_valid_q <= 1'b1;
                fifo_data_q  <= {1'b0, bus.sample_data};
            end else begin
                fifo_valid_q <= 1'b0;
            end
        end
    end
`endif

    assign bus.fifo_valid = fifo_valid_q;
    assign bus.fifo_data  = fifo_data_q;

endmodule

// File: tb/tb_trace_bp_sampler.sv
// Directed bench for trace_bp_sampler (sample_width_p = counter_width_p = 4).
// Each step drives sample_data = step index; outputs are checked 1 ns after
// the rising edge against hand-computed words. Expectations for stalls
// follow the TRACE_BP_MARKER_EN build setting.
module tb_trace_bp_sampler;

    logic clk;
    logic reset_n_i;
    int   vectors;
    int   miscompares;

    trace_bp_sampler_if #(.sample_width_p(4)) bus ();

    trace_bp_sampler #(
        .sample_width_p (4),
        .counter_width_p(4)
    ) dut (
        .clk      (clk),
        .reset_n_i(reset_n_i),
        .bus      (bus)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge, then settle after the rising edge.
    task automatic apply_stimulus(input int idx, input logic v, input logic r);
        logic [31:0] idx_bits;
        idx_bits = idx;
        @(negedge clk);
        bus.sample_data  = idx_bits[3:0];
        bus.sample_valid = v;
        bus.fifo_ready   = r;
        @(posedge clk);
        #1;
    endtask

    // Compare fifo_valid, and fifo_data whenever a word is expected.
    task automatic check_output(input string tag, input logic exp_v, input logic [4:0] exp_d);
        vectors++;
        assert (bus.fifo_valid === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s.valid observed=%b expected=%b", tag, bus.fifo_valid, exp_v);
        end
        if (exp_v) begin
            vectors++;
            assert (bus.fifo_data === exp_d) else begin
                miscompares++;
                $error("[TB] FAIL %s.data observed=%h expected=%h", tag, bus.fifo_data, exp_d);
            end
        end
    endtask

    // Directed sequence.
    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset_n_i        = 1'b0;
        bus.sample_data  = '0;
        bus.sample_valid = 1'b0;
        bus.fifo_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        vectors++;
        assert (bus.fifo_data === 5'h00) else begin
            miscompares++;
            $error("[TB] FAIL reset.data observed=%h expected=%h", bus.fifo_data, 5'h00);
        end
        check_output("reset", 1'b0, 5'h00);
        @(negedge clk);
        reset_n_i = 1'b1;
        $display("[TB] reset released");

        // Free-flowing stream with a two-cycle gap.
        apply_stimulus(1, 1'b1, 1'b1);  check_output("flow1", 1'b1, 5'h01);
        apply_stimulus(2, 1'b1, 1'b1);  check_output("flow2", 1'b1, 5'h02);
        apply_stimulus(3, 1'b0, 1'b1);  check_output("gap3",  1'b0, 5'h00);
        apply_stimulus(4, 1'b0, 1'b1);  check_output("gap4",  1'b0, 5'h00);
        apply_stimulus(5, 1'b1, 1'b1);  check_output("flow5", 1'b1, 5'h05);
        apply_stimulus(6, 1'b1, 1'b1);  check_output("flow6", 1'b1, 5'h06);
        apply_stimulus(7, 1'b1, 1'b1);  check_output("flow7", 1'b1, 5'h07);

        // Two-cycle stall: samples 8 and 9 are blocked.
        apply_stimulus(8, 1'b1, 1'b0);  check_output("stall8", 1'b1, 5'h07);
        apply_stimulus(9, 1'b1, 1'b0);  check_output("stall9", 1'b1, 5'h07);
`ifdef TRACE_BP_MARKER_EN
        apply_stimulus(10, 1'b1, 1'b1); check_output("marker",  1'b1, 5'h12);
        apply_stimulus(11, 1'b1, 1'b1); check_output("post10",  1'b1, 5'h0A);
        apply_stimulus(12, 1'b1, 1'b1); check_output("post11",  1'b1, 5'h0B);
        apply_stimulus(13, 1'b0, 1'b1); check_output("post12",  1'b1, 5'h0C);
        apply_stimulus(14, 1'b0, 1'b1); check_output("drained", 1'b0, 5'h00);
`else
        apply_stimulus(10, 1'b1, 1'b1); check_output("post10",  1'b1, 5'h0A);
        apply_stimulus(11, 1'b1, 1'b1); check_output("post11",  1'b1, 5'h0B);
        apply_stimulus(12, 1'b1, 1'b1); check_output("post12",  1'b1, 5'h0C);
        apply_stimulus(13, 1'b0, 1'b1); check_output("idle13",  1'b0, 5'h00);
        apply_stimulus(14, 1'b0, 1'b1); check_output("idle14",  1'b0, 5'h00);
`endif

        // Twenty-cycle stall: the count saturates.
        apply_stimulus(15, 1'b1, 1'b1); check_output("presat", 1'b1, 5'h0F);
        for (int c = 16; c <= 35; c++) begin
            apply_stimulus(c, 1'b1, 1'b0);
            check_output("sathold", 1'b1, 5'h0F);
        end
`ifdef TRACE_BP_MARKER_EN
        apply_stimulus(36, 1'b1, 1'b1); check_output("satmark", 1'b1, 5'h1F);
        apply_stimulus(37, 1'b0, 1'b1); check_output("sat36",   1'b1, 5'h04);
        apply_stimulus(38, 1'b0, 1'b1); check_output("satidle", 1'b0, 5'h00);
`else
        apply_stimulus(36, 1'b1, 1'b1); check_output("sat36",   1'b1, 5'h04);
        apply_stimulus(37, 1'b0, 1'b1); check_output("satidle", 1'b0, 5'h00);
        apply_stimulus(38, 1'b0, 1'b1); check_output("satidl2", 1'b0, 5'h00);
`endif

        // Reset in the middle of a stall with three samples dropped.
        apply_stimulus(39, 1'b1, 1'b1); check_output("pre_rst", 1'b1, 5'h07);
        apply_stimulus(40, 1'b1, 1'b0); check_output("rstall0", 1'b1, 5'h07);
        apply_stimulus(41, 1'b1, 1'b0); check_output("rstall1", 1'b1, 5'h07);
        apply_stimulus(42, 1'b1, 1'b0); check_output("rstall2", 1'b1, 5'h07);
        reset_n_i        = 1'b0;
        bus.sample_valid = 1'b0;
        #1;
        check_output("async_rst", 1'b0, 5'h00);
        vectors++;
        assert (bus.fifo_data === 5'h00) else begin
            miscompares++;
            $error("[TB] FAIL async_rst.data observed=%h expected=%h", bus.fifo_data, 5'h00);
        end
        @(posedge clk);
        #1;
        check_output("in_rst", 1'b0, 5'h00);
        @(negedge clk);
        reset_n_i = 1'b1;
        apply_stimulus(43, 1'b0, 1'b1); check_output("no_marker", 1'b0, 5'h00);
        apply_stimulus(44, 1'b1, 1'b1); check_output("resume44",  1'b1, 5'h0C);
        apply_stimulus(45, 1'b1, 1'b1); check_output("resume45",  1'b1, 5'h0D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
